// File: rtl/regbus_master_if.sv
// Core request/response and register-bus signal bundle for regbus_master.
// The master modport is the bridge side; slave is the core + responder side.
interface regbus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        wr_en;
    logic [3:0]  be;
    logic [15:0] wr_addr;
    logic [31:0] wdata;

    logic        rd_en;
    logic [15:0] rd_addr;
    logic [31:0] rdata;
    logic        rd_rdy;

    modport master (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_size,
        input  req_signed,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        input  resp_ready,
        output resp_rdata,
        output resp_err,
        output wr_en,
        output be,
        output wr_addr,
        output wdata,
        output rd_en,
        output rd_addr,
        input  rdata,
        input  rd_rdy
    );

    modport slave (
        output req_valid,
        output req_we,
        output req_addr,
        output req_size,
        output req_signed,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        output resp_ready,
        input  resp_rdata,
        input  resp_err,
        input  wr_en,
        input  be,
        input  wr_addr,
        input  wdata,
        input  rd_en,
        input  rd_addr,
        output rdata,
        output rd_rdy
    );
endinterface

// File: rtl/regbus_master.sv
// Bridges single core load/store requests onto a 32-bit register bus,
// with lane steering, load formatting and a bounded read wait.
module regbus_master #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rstb,
    regbus_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WAIT,
        RESP
    } state_e;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          misalign;
    logic          bad_req;

    function automatic logic [3:0] be_of(input logic [1:0] size,
                                         input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b1111;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    m = 4'b0001;
                    2'd1:    m = 4'b0010;
                    2'd2:    m = 4'b0100;
                    default: m = 4'b1000;
                endcase
            end
            2'd1:    m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0]  size,
                                             input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] raw,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane,
                                             input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = lane[1] ? raw[31:16] : raw[15:0];
        case (size)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign misalign = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    assign bad_req  = (bus.req_size == 2'd3) || misalign;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bad_req) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = bus.req_we ? WR : RD;
                        addr_d  = {bus.req_addr[15:2], 2'b00};
                        lane_d  = bus.req_addr[1:0];
                        size_d  = bus.req_size;
                        sgn_d   = bus.req_signed;
                        be_d    = be_of(bus.req_size, bus.req_addr[1:0]);
                        wdata_d = wdata_of(bus.req_size, bus.req_wdata);
                    end
                end
            end
            WR: begin
                state_d = RESP;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            RD: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A response landing on the expiry cycle still wins.
                if (bus.rd_rdy) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = fmt_load(bus.rdata, size_q, lane_q, sgn_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.wr_en      = (state_q == WR);
    assign bus.be         = be_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wdata      = wdata_q;
    assign bus.rd_en      = (state_q == RD);
    assign bus.rd_addr    = addr_q;

endmodule

// File: tb/tb_regbus_master.sv
// Directed bench for regbus_master: stores, formatted loads, errors,
// read timeout, response back-pressure and mid-transaction reset.
module tb_regbus_master;

    logic clk;
    logic rstb;
    int   n_cmp;
    int   n_bad;
    int   wr_pulses;
    int   rd_pulses;
    int   wr0;
    int   rd0;

    regbus_master_if bif ();

    regbus_master #(.TIMEOUT(15)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.wr_en) wr_pulses++;
        if (bif.rd_en) rd_pulses++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic        we,
                         input logic [15:0] a,
                         input logic [1:0]  sz,
                         input logic        sgn,
                         input logic [31:0] d);
        @(negedge clk);
        bif.req_we     = we;
        bif.req_addr   = a;
        bif.req_size   = sz;
        bif.req_signed = sgn;
        bif.req_wdata  = d;
        bif.req_valid  = 1'b1;
        chk("req_ready_idle", 32'(bif.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a,
                            input logic [1:0]  sz,
                            input logic [31:0] d,
                            input logic [15:0] exp_a,
                            input logic [3:0]  exp_be,
                            input logic [31:0] exp_wd);
        wr0 = wr_pulses;
        issue(1'b1, a, sz, 1'b0, d);
        @(negedge clk);
        chk("st_wr_en", 32'(bif.wr_en), 32'd1);
        chk("st_wr_addr", 32'(bif.wr_addr), 32'(exp_a));
        chk("st_be", 32'(bif.be), 32'(exp_be));
        chk("st_wdata", bif.wdata, exp_wd);
        chk("st_busy", 32'(bif.req_ready), 32'd0);
        @(negedge clk);
        chk("st_resp_valid", 32'(bif.resp_valid), 32'd1);
        chk("st_resp_err", 32'(bif.resp_err), 32'd0);
        chk("st_resp_rdata", bif.resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("st_one_pulse", 32'(wr_pulses - wr0), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] a,
                           input logic [1:0]  sz,
                           input logic        sgn,
                           input logic [31:0] raw,
                           input logic [15:0] exp_a,
                           input logic [31:0] exp_d);
        rd0 = rd_pulses;
        issue(1'b0, a, sz, sgn, 32'd0);
        @(negedge clk);
        chk("ld_rd_en", 32'(bif.rd_en), 32'd1);
        chk("ld_rd_addr", 32'(bif.rd_addr), 32'(exp_a));
        @(posedge clk);
        #1;
        bif.rdata  = raw;
        bif.rd_rdy = 1'b1;
        @(negedge clk);
        chk("ld_not_yet", 32'(bif.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        bif.rd_rdy = 1'b0;
        @(negedge clk);
        chk("ld_resp_valid_n3", 32'(bif.resp_valid), 32'd1);
        chk("ld_resp_rdata", bif.resp_rdata, exp_d);
        chk("ld_resp_err", 32'(bif.resp_err), 32'd0);
        @(posedge clk);
        #1;
        chk("ld_one_pulse", 32'(rd_pulses - rd0), 32'd1);
    endtask

    task automatic do_err(input logic        we,
                          input logic [15:0] a,
                          input logic [1:0]  sz);
        wr0 = wr_pulses;
        rd0 = rd_pulses;
        issue(we, a, sz, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("err_resp_valid", 32'(bif.resp_valid), 32'd1);
        chk("err_resp_err", 32'(bif.resp_err), 32'd1);
        chk("err_resp_rdata", bif.resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("err_no_bus", 32'((wr_pulses - wr0) + (rd_pulses - rd0)), 32'd0);
    endtask

    // Word load at 0x0004; rd_rdy optionally on the 15th WAIT cycle.
    task automatic do_wait(input logic late_rdy, input logic [31:0] raw);
        issue(1'b0, 16'h0004, 2'd2, 1'b0, 32'd0);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (k == 15 && late_rdy) begin
                bif.rdata  = raw;
                bif.rd_rdy = 1'b1;
            end
        end
        @(negedge clk);
        chk("wait_no_early_resp", 32'(bif.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        bif.rd_rdy = 1'b0;
        @(negedge clk);
        chk("wait_resp_valid", 32'(bif.resp_valid), 32'd1);
        chk("wait_resp_err", 32'(bif.resp_err), late_rdy ? 32'd0 : 32'd1);
        chk("wait_resp_rdata", bif.resp_rdata, late_rdy ? raw : 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(bif.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bif.resp_valid), 32'd0);
        chk({tag, "_resp_err"}, 32'(bif.resp_err), 32'd0);
        chk({tag, "_resp_rdata"}, bif.resp_rdata, 32'd0);
        chk({tag, "_wr_en"}, 32'(bif.wr_en), 32'd0);
        chk({tag, "_rd_en"}, 32'(bif.rd_en), 32'd0);
        chk({tag, "_be"}, 32'(bif.be), 32'd0);
        chk({tag, "_addr"}, 32'({bif.wr_addr, bif.rd_addr}), 32'd0);
        chk({tag, "_wdata"}, bif.wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        wr_pulses      = 0;
        rd_pulses      = 0;
        rstb           = 1'b0;
        bif.req_valid  = 1'b0;
        bif.req_we     = 1'b0;
        bif.req_addr   = '0;
        bif.req_size   = '0;
        bif.req_signed = 1'b0;
        bif.req_wdata  = '0;
        bif.resp_ready = 1'b1;
        bif.rdata      = '0;
        bif.rd_rdy     = 1'b0;

        #12;
        chk_reset_outs("rst");
        @(negedge clk);
        rstb = 1'b1;

        do_store(16'h0001, 2'd0, 32'h0000_00A5, 16'h0000, 4'b0010, 32'hA5A5_A5A5);
        do_store(16'h0002, 2'd1, 32'h1234_BEEF, 16'h0000, 4'b1100, 32'hBEEF_BEEF);
        do_store(16'h0010, 2'd2, 32'hDEAD_BEEF, 16'h0010, 4'b1111, 32'hDEAD_BEEF);

        do_load(16'h0002, 2'd1, 1'b1, 32'h8001_1234, 16'h0000, 32'hFFFF_8001);
        do_load(16'h0001, 2'd0, 1'b1, 32'h0000_F000, 16'h0000, 32'hFFFF_FFF0);
        do_load(16'h0000, 2'd1, 1'b0, 32'h1234_8765, 16'h0000, 32'h0000_8765);
        do_load(16'h000C, 2'd2, 1'b1, 32'hCAFE_F00D, 16'h000C, 32'hCAFE_F00D);

        do_err(1'b0, 16'h0006, 2'd2);
        do_err(1'b1, 16'h0001, 2'd1);
        do_err(1'b0, 16'h0000, 2'd3);

        do_wait(1'b0, 32'd0);
        do_wait(1'b1, 32'h1357_9BDF);

        // Back-pressure: response must hold while resp_ready stays low.
        bif.resp_ready = 1'b0;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        issue(1'b0, 16'h0003, 2'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        bif.rdata  = 32'h8000_0000;
        bif.rd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bif.rd_rdy = 1'b0;
        bif.rdata  = 32'h0000_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(bif.resp_valid), 32'd1);
            chk("bp_resp_rdata", bif.resp_rdata, 32'h0000_0080);
            chk("bp_req_ready", 32'(bif.req_ready), 32'd0);
        end
        bif.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_single_access", 32'((rd_pulses - rd0) + (wr_pulses - wr0)), 32'd1);
        @(negedge clk);
        chk("bp_idle_after", 32'(bif.req_ready), 32'd1);

        // Reset pulse while waiting on the read responder.
        issue(1'b0, 16'h0008, 2'd2, 1'b0, 32'd0);
        @(negedge clk);
        chk("rw_rd_en", 32'(bif.rd_en), 32'd1);
        @(posedge clk);
        #2;
        rstb = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("midrst_no_resp", 32'(bif.resp_valid), 32'd0);
        do_store(16'h0002, 2'd1, 32'h1234_BEEF, 16'h0000, 4'b1100, 32'hBEEF_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
